pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter and next-PC stage that drives the instruction-memory address in the single-cycle MIPS datapath. Each cycle it holds the address of the instruction being executed and selects the next address from sequential, branch, jump or jump-register control. An illegal next address (misaligned or outside the instruction-memory window) moves it into a sticky fault state. It also keeps a retired-instruction counter for the test harness.

## Interface
- RESET_PC, 32'h0000_3000: PC value after reset, and the base of the instruction-memory window.
- IM_WORDS, 4096: instruction-memory depth in words. The legal window is [RESET_PC, RESET_PC + 4*IM_WORDS).

- clk  in  1: the single clock; all state updates on its rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- stall  in  1: hold the PC this cycle.
- br_taken  in  1: conditional branch resolved as taken.
- br_imm  in  16: branch immediate, a signed word offset.
- j_en  in  1: j/jal.
- j_index  in  26: jump instr_index field.
- jr_en  in  1: jr/jalr.
- jr_target  in  32: register jump target.
- pc  out  32: current instruction address, fed to the IM.
- pc_plus4  out  32: pc + 4, used as the link value.
- fetch_valid  out  1: pc addresses a legal instruction and the stage is running.
- fault  out  1: sticky fault flag.
- fault_pc  out  32: the rejected next-PC value.
- retired  out  32: count of instructions completed.

## Operation
- State machine with two states, RUN and FAULT.
- Reset values:
  - pc = RESET_PC
  - state = RUN
  - fault = 0
  - fault_pc = 0
  - retired = 0
  - fetch_valid = 1 once reset_n is high
- Next-PC select (combinational), highest priority first:
  1. jr_en: jr_target.
  2. j_en: {pc_plus4[31:28], j_index, 2'b00}.
  3. br_taken: pc_plus4 + (sign_extend(br_imm) << 2). Arithmetic is 32-bit and wraps modulo 2^32.
  4. Otherwise pc_plus4.
- pc_plus4 = pc + 4. It wraps modulo 2^32; a wrapped value fails the range check.
- Legal next PC: npc[1:0] == 0 and RESET_PC <= npc < RESET_PC + 4*IM_WORDS. The upper bound is computed without overflow, as a 33-bit compare.
- RUN, stall = 1:
  - pc and retired hold.
  - Any redirect is dropped; decode re-presents it next cycle from the same instruction.
  - No fault check is made.
- RUN, stall = 0, npc legal: pc <= npc; retired <= retired + 1, saturating at 32'hFFFF_FFFF.
- RUN, stall = 0, npc illegal:
  - pc holds.
  - fault_pc <= npc.
  - Go to FAULT.
  - retired still increments, because the faulting instruction completed.
- FAULT:
  - pc, fault_pc and retired hold.
  - All control inputs are ignored.
  - Only reset_n leaves this state.
- Outputs: fault = (state == FAULT); fetch_valid = (state == RUN).
- reset_n low at any time, including mid-stall or in FAULT, forces all reset values immediately, without waiting for clk.

## Timing
- pc, state, fault_pc and retired are registers.
- pc_plus4, fault and fetch_valid are derived directly from registers, with no path from any input.
- Redirect latency is one edge: a control input sampled at edge N appears on pc after edge N.
- Simultaneous jr_en, j_en and br_taken: priority order only, no error.
- stall together with an illegal npc: stall wins and no fault is raised.
- Reset release: the first update happens at the first rising clk edge after reset_n goes high.

## Test plan
- Reset then 3 free cycles: pc goes 0x3000, 0x3004, 0x3008, 0x300C; retired = 3; fetch_valid = 1 throughout.
- At pc = 0x3010, br_taken with br_imm = 16'hFFFC: next pc = 0x3004. With br_imm = 16'h0002: next pc = 0x301C.
- At pc = 0x3020, j_en with j_index = 26'h0000C10 and jr_en with jr_target = 0x3100 in the same cycle: next pc = 0x3100 (jr wins). The same test without jr_en gives 0x3040.
- stall held for 2 cycles at pc = 0x3008 with br_taken: pc stays 0x3008 and retired is unchanged. Release the stall with no control: pc = 0x300C.
- jr_target = 0x3002 gives fault = 1, fault_pc = 0x3002, pc held, fetch_valid = 0, and FAULT persists through 5 cycles of random input. jr_target = 0x7000 (beyond 0x6FFC) faults the same way.
- reset_n pulsed low between clock edges while in FAULT: pc = 0x3000 and fault = 0 before the next edge; retired = 0.

Source files
------------

// File: rtl/pc_fetch.sv
// Program counter and next-PC select for the single-cycle MIPS fetch stage.
// Latency: a redirect sampled at edge N is visible on pc after edge N.
// Backpressure: stall holds pc and retired; an illegal next PC parks the stage in FAULT until reset.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_imm,
    input  logic        j_en,
    input  logic [25:0] j_index,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] retired
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    // 33-bit window bounds so RESET_PC + 4*IM_WORDS cannot wrap
    localparam logic [32:0] PC_BASE  = {1'b0, RESET_PC};
    localparam logic [32:0] PC_LIMIT = PC_BASE + (33'(IM_WORDS) << 2);

    logic [0:0]  state;
    logic [31:0] npc;
    logic [31:0] br_offset;
    logic        npc_legal;

    assign pc_plus4    = pc + 32'd4;
    assign fault       = (state == ST_FAULT);
    assign fetch_valid = (state == ST_RUN);
    assign br_offset   = {{14{br_imm[15]}}, br_imm, 2'b00};

    always_comb begin
        npc = pc_plus4;
        if (jr_en) begin
            npc = jr_target;
        end else if (j_en) begin
            npc = {pc_plus4[31:28], j_index, 2'b00};
        end else if (br_taken) begin
            npc = pc_plus4 + br_offset;
        end
    end

    assign npc_legal = (npc[1:0] == 2'b00)
                    && ({1'b0, npc} >= PC_BASE)
                    && ({1'b0, npc} <  PC_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_RUN;
            pc       <= RESET_PC;
            fault_pc <= 32'd0;
            retired  <= 32'd0;
        end else begin
            if (state == ST_RUN && !stall) begin
                // the instruction at pc completes whether or not its successor is legal
                if (retired != 32'hFFFF_FFFF) begin
                    retired <= retired + 32'd1;
                end
                if (npc_legal) begin
                    pc <= npc;
                end else begin
                    fault_pc <= npc;
                    state    <= ST_FAULT;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequential flow, branch/jump priority, stall, fault and async reset.
module tb_pc_fetch;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_imm;
    logic        j_en;
    logic [25:0] j_index;
    logic        jr_en;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    pc_fetch dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_imm     (br_imm),
        .j_en       (j_en),
        .j_index    (j_index),
        .jr_en      (jr_en),
        .jr_target  (jr_target),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .fetch_valid(fetch_valid),
        .fault      (fault),
        .fault_pc   (fault_pc),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_imm    = 16'h0000;
        j_en      = 1'b0;
        j_index   = 26'h0;
        jr_en     = 1'b0;
        jr_target = 32'h0;
    endtask

    // advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_jr(input logic [31:0] tgt);
        idle();
        jr_en     = 1'b1;
        jr_target = tgt;
        step();
        idle();
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        #12;
        chk("rst_pc", pc, 32'h3000);
        chk("rst_pc4", pc_plus4, 32'h3004);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_fault_pc", fault_pc, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_valid", {31'd0, fetch_valid}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("seq_0", pc, 32'h3004);
        step();
        chk("seq_1", pc, 32'h3008);
        step();
        chk("seq_2", pc, 32'h300C);
        chk("seq_retired", retired, 32'd3);
        chk("seq_valid", {31'd0, fetch_valid}, 32'd1);
        step();
        chk("seq_3", pc, 32'h3010);

        br_taken = 1'b1; br_imm = 16'hFFFC;
        step(); idle();
        chk("br_back", pc, 32'h3004);
        chk("br_back_ret", retired, 32'd5);
        step(); step(); step();
        chk("br_fwd_pre", pc, 32'h3010);
        br_taken = 1'b1; br_imm = 16'h0002;
        step(); idle();
        chk("br_fwd", pc, 32'h301C);
        step();
        chk("to_3020", pc, 32'h3020);

        j_en = 1'b1; j_index = 26'h0000C10; br_taken = 1'b1; br_imm = 16'h0010;
        jr_en = 1'b1; jr_target = 32'h3100;
        step(); idle();
        chk("jr_wins", pc, 32'h3100);
        do_jr(32'h3020);
        chk("jr_3020", pc, 32'h3020);
        j_en = 1'b1; j_index = 26'h0000C10; br_taken = 1'b1; br_imm = 16'h0010;
        step(); idle();
        chk("j_over_br", pc, 32'h3040);
        chk("j_ret", retired, 32'd13);

        do_jr(32'h3008);
        stall = 1'b1; br_taken = 1'b1; br_imm = 16'h0005;
        step();
        chk("stall_pc_1", pc, 32'h3008);
        step();
        chk("stall_pc_2", pc, 32'h3008);
        chk("stall_ret", retired, 32'd14);
        idle();
        step();
        chk("unstall_pc", pc, 32'h300C);
        chk("unstall_ret", retired, 32'd15);

        stall = 1'b1; jr_en = 1'b1; jr_target = 32'h3002;
        step(); idle();
        chk("stall_illegal_fault", {31'd0, fault}, 32'd0);
        chk("stall_illegal_pc", pc, 32'h300C);

        do_jr(32'h3002);
        chk("mis_fault", {31'd0, fault}, 32'd1);
        chk("mis_fault_pc", fault_pc, 32'h3002);
        chk("mis_pc", pc, 32'h300C);
        chk("mis_valid", {31'd0, fetch_valid}, 32'd0);
        chk("mis_ret", retired, 32'd16);
        for (int i = 0; i < 5; i++) begin
            stall     = 1'($urandom);
            br_taken  = 1'($urandom);
            br_imm    = 16'($urandom);
            j_en      = 1'($urandom);
            j_index   = 26'($urandom);
            jr_en     = 1'($urandom);
            jr_target = 32'h3000 + (32'($urandom_range(0, 255)) << 2);
            step();
            chk("hold_fault", {31'd0, fault}, 32'd1);
            chk("hold_pc", pc, 32'h300C);
            chk("hold_fault_pc", fault_pc, 32'h3002);
            chk("hold_ret", retired, 32'd16);
        end
        idle();

        pulse_reset();
        chk("arst_pc", pc, 32'h3000);
        chk("arst_fault", {31'd0, fault}, 32'd0);
        chk("arst_ret", retired, 32'd0);
        chk("arst_fault_pc", fault_pc, 32'd0);
        chk("arst_valid", {31'd0, fetch_valid}, 32'd1);

        do_jr(32'h6FFC);
        chk("top_legal", pc, 32'h6FFC);
        chk("top_legal_fault", {31'd0, fault}, 32'd0);
        step();
        chk("top_wrap_fault", {31'd0, fault}, 32'd1);
        chk("top_wrap_fault_pc", fault_pc, 32'h7000);
        chk("top_wrap_pc", pc, 32'h6FFC);
        chk("top_wrap_ret", retired, 32'd2);

        pulse_reset();
        do_jr(32'h7000);
        chk("hi_fault", {31'd0, fault}, 32'd1);
        chk("hi_fault_pc", fault_pc, 32'h7000);
        chk("hi_pc", pc, 32'h3000);
        chk("hi_ret", retired, 32'd1);

        pulse_reset();
        do_jr(32'h2FFC);
        chk("lo_fault", {31'd0, fault}, 32'd1);
        chk("lo_fault_pc", fault_pc, 32'h2FFC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
